// File: rtl/regfile_seq_ctrl_if.sv
// Instruction handshake and register-file port bundle for regfile_seq_ctrl.
// The slave modport is the controller; the master modport is the requester/register-file side.
interface regfile_seq_ctrl_if #(
    parameter int DW = 8,
    parameter int AW = 3
);
    logic          instr_valid;
    logic          instr_ready;
    logic [2:0]    opcode;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [DW-1:0] imm;
    logic [AW-1:0] RX;
    logic [AW-1:0] RY;
    logic [AW-1:0] RW;
    logic          WEN;
    logic [DW-1:0] busW;
    logic [DW-1:0] busX;
    logic [DW-1:0] busY;
    logic          done;
    logic [DW-1:0] result;
    logic          carry;

    modport master (
        output instr_valid, opcode, rd, rs, rt, imm, busX, busY,
        input  instr_ready, RX, RY, RW, WEN, busW, done, result, carry
    );

    modport slave (
        input  instr_valid, opcode, rd, rs, rt, imm, busX, busY,
        output instr_ready, RX, RY, RW, WEN, busW, done, result, carry
    );
endinterface

// File: rtl/regfile_seq_ctrl.sv
// Four-state micro-sequencer: accept, read the register file, execute, write back.
// Owns every port of an 8x8 register file and retires one instruction per four cycles.
module regfile_seq_ctrl #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input logic              Clk,
    input logic              Rst_n,
    regfile_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_e;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LI, OP_SLT, OP_NOP
    } op_e;

    state_e        state_q, state_d;
    op_e           op_q;
    logic [AW-1:0] rd_q, rx_q, ry_q, rw_q;
    logic [DW-1:0] imm_q, opa_q, opb_q, busw_q;
    logic [DW-1:0] result_q, result_d;
    logic          carry_q, carry_d;
    logic [DW:0]   sum;
    logic          accept;

    assign accept = bus.instr_valid && (state_q == IDLE);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept) state_d = READ;
            READ:  state_d = EXEC;
            EXEC:  state_d = WRITE;
            WRITE: state_d = IDLE;
        endcase
    end

    // Handshake and write strobes depend on registered state only.
    always_comb begin
        bus.instr_ready = (state_q == IDLE);
        bus.done        = (state_q == WRITE);
        bus.WEN         = (state_q == WRITE) && (rd_q != '0) && (op_q != OP_NOP);
    end

    always_comb begin
        sum      = {1'b0, opa_q} + {1'b0, opb_q};
        result_d = result_q;
        carry_d  = 1'b0;
        unique case (op_q)
            OP_ADD: begin result_d = sum[DW-1:0];    carry_d = sum[DW]; end
            OP_SUB: begin result_d = opa_q - opb_q;  carry_d = (opa_q < opb_q); end
            OP_AND: result_d = opa_q & opb_q;
            OP_OR:  result_d = opa_q | opb_q;
            OP_XOR: result_d = opa_q ^ opb_q;
            OP_LI:  result_d = imm_q;
            OP_SLT: result_d = DW'(opa_q < opb_q);
            OP_NOP: carry_d  = carry_q;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            op_q     <= OP_ADD;
            rd_q     <= '0;
            imm_q    <= '0;
            rx_q     <= '0;
            ry_q     <= '0;
            rw_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            busw_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (accept) begin
                    op_q  <= op_e'(bus.opcode);
                    rd_q  <= bus.rd;
                    imm_q <= bus.imm;
                    rx_q  <= bus.rs;
                    ry_q  <= bus.rt;
                end
                READ: begin
                    opa_q <= bus.busX;
                    opb_q <= bus.busY;
                end
                EXEC: begin
                    result_q <= result_d;
                    carry_q  <= carry_d;
                    busw_q   <= result_d;
                    rw_q     <= rd_q;
                end
                WRITE: ;
            endcase
        end
    end

    assign bus.RX     = rx_q;
    assign bus.RY     = ry_q;
    assign bus.RW     = rw_q;
    assign bus.busW   = busw_q;
    assign bus.result = result_q;
    assign bus.carry  = carry_q;
endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Bench for regfile_seq_ctrl: models the 8x8 register file, drives directed instructions,
// and a negedge monitor checks each retirement against hand-computed expectations.
module tb_regfile_seq_ctrl;
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                           XOR_ = 3'd4, LI = 3'd5, SLT = 3'd6, NOP = 3'd7;

    typedef struct {
        logic [7:0] res;
        logic       c;
        logic       wen;
        logic [2:0] rd;
        int         acc;
    } exp_t;

    logic Clk = 1'b0;
    logic Rst_n = 1'b1;
    logic clr_rf = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   passes = 0;
    int   done_cnt = 0;
    int   last_acc = 0;
    exp_t sb[$];
    logic [7:0] rf [8];

    regfile_seq_ctrl_if #(.DW(8), .AW(3)) ifc ();

    regfile_seq_ctrl #(.DW(8), .AW(3)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (ifc)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    always @(posedge Clk) begin
        if (clr_rf) begin
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else if (ifc.WEN && ifc.RW != 3'd0) begin
            rf[ifc.RW] <= ifc.busW;
        end
    end
    assign ifc.busX = rf[ifc.RX];
    assign ifc.busY = rf[ifc.RY];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else passes++;
    endtask

    // Cycle n is the interval ending at edge n, so done seen here is in cycle cyc+1.
    always @(negedge Clk) begin
        if (Rst_n) begin
            chk("wen_outside_write", {31'd0, ifc.WEN && !ifc.done}, 32'd0);
            if (ifc.done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", {24'd0, ifc.result}, {24'd0, e.res});
                    chk("carry", {31'd0, ifc.carry}, {31'd0, e.c});
                    chk("wen", {31'd0, ifc.WEN}, {31'd0, e.wen});
                    chk("done_latency", cyc + 1, e.acc + 3);
                    chk("ready_low_in_write", {31'd0, ifc.instr_ready}, 32'd0);
                    if (e.wen) begin
                        chk("rw", {29'd0, ifc.RW}, {29'd0, e.rd});
                        chk("busw", {24'd0, ifc.busW}, {24'd0, e.res});
                    end
                end
            end
        end
    end

    // Called #1 after a posedge; returns #1 after the accept edge with instr_valid still high.
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input logic [7:0] imm, input logic [7:0] res,
                         input logic c, input bit push);
        bit ok = 0;
        exp_t e;
        ifc.opcode = op; ifc.rd = rd; ifc.rs = rs; ifc.rt = rt; ifc.imm = imm;
        ifc.instr_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (ifc.instr_ready) begin ok = 1; break; end
            @(posedge Clk); #1;
        end
        chk("accept_timeout", {31'd0, ok}, 32'd1);
        last_acc = cyc + 1;
        e.res = res; e.c = c; e.rd = rd; e.acc = last_acc;
        e.wen = (rd != 3'd0) && (op != NOP);
        if (push) sb.push_back(e);
        @(posedge Clk); #1;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0 && ifc.instr_ready) begin ok = 1; break; end
            @(posedge Clk); #1;
        end
        chk("idle_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic one(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt, input logic [7:0] imm, input logic [7:0] res,
                       input logic c);
        issue(op, rd, rs, rt, imm, res, c, 1'b1);
        ifc.instr_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a1, a2, a3, d0;
        ifc.instr_valid = 1'b0; ifc.opcode = '0; ifc.rd = '0; ifc.rs = '0; ifc.rt = '0; ifc.imm = '0;

        // Asynchronous reset before any clock edge.
        #2 Rst_n = 1'b0;
        #1;
        chk("rst_ready", {31'd0, ifc.instr_ready}, 32'd1);
        chk("rst_wen", {31'd0, ifc.WEN}, 32'd0);
        chk("rst_done", {31'd0, ifc.done}, 32'd0);
        chk("rst_result", {24'd0, ifc.result}, 32'd0);
        chk("rst_carry", {31'd0, ifc.carry}, 32'd0);
        chk("rst_rw", {29'd0, ifc.RW}, 32'd0);
        chk("rst_busw", {24'd0, ifc.busW}, 32'd0);
        repeat (2) @(posedge Clk);
        @(negedge Clk) begin Rst_n = 1'b1; clr_rf = 1'b0; end
        @(posedge Clk); #1;

        // LI then ADD with carry out.
        one(LI,  3'd1, 3'd0, 3'd0, 8'h7F, 8'h7F, 1'b0);
        one(LI,  3'd2, 3'd0, 3'd0, 8'h81, 8'h81, 1'b0);
        one(LI,  3'd3, 3'd0, 3'd0, 8'hEE, 8'hEE, 1'b0);
        one(ADD, 3'd3, 3'd1, 3'd2, 8'h00, 8'h00, 1'b1);
        chk("rf_r3_add", {24'd0, rf[3]}, 32'h00);

        // SUB borrow, NOP keeps result/carry, SLT.
        one(LI,  3'd1, 3'd0, 3'd0, 8'h05, 8'h05, 1'b0);
        one(LI,  3'd2, 3'd0, 3'd0, 8'h09, 8'h09, 1'b0);
        one(SUB, 3'd4, 3'd1, 3'd2, 8'h00, 8'hFC, 1'b1);
        chk("rf_r4_sub", {24'd0, rf[4]}, 32'hFC);
        one(NOP, 3'd4, 3'd2, 3'd1, 8'h33, 8'hFC, 1'b1);
        one(SLT, 3'd5, 3'd1, 3'd2, 8'h00, 8'h01, 1'b0);
        chk("rf_r5_slt", {24'd0, rf[5]}, 32'h01);
        chk("rf_r4_after_nop", {24'd0, rf[4]}, 32'hFC);

        // Writes to R0 are suppressed; R0 still reads as zero.
        one(LI,  3'd6, 3'd0, 3'd0, 8'h11, 8'h11, 1'b0);
        one(LI,  3'd0, 3'd0, 3'd0, 8'hAA, 8'hAA, 1'b0);
        chk("rf_r0", {24'd0, rf[0]}, 32'h00);
        one(ADD, 3'd6, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0);
        chk("rf_r6_zero", {24'd0, rf[6]}, 32'h00);

        // Back-to-back with instr_valid held high; XOR depends on the two before it.
        d0 = done_cnt;
        issue(AND_, 3'd3, 3'd1, 3'd2, 8'h00, 8'h01, 1'b0, 1'b1); a1 = last_acc;
        issue(OR_,  3'd4, 3'd1, 3'd2, 8'h00, 8'h0D, 1'b0, 1'b1); a2 = last_acc;
        issue(XOR_, 3'd5, 3'd3, 3'd4, 8'h00, 8'h0C, 1'b0, 1'b1); a3 = last_acc;
        ifc.instr_valid = 1'b0;
        wait_idle();
        chk("b2b_gap1", a2 - a1, 32'd4);
        chk("b2b_gap2", a3 - a2, 32'd4);
        chk("b2b_done_count", done_cnt - d0, 32'd3);
        chk("rf_r3_and", {24'd0, rf[3]}, 32'h01);
        chk("rf_r4_or", {24'd0, rf[4]}, 32'h0D);
        chk("rf_r5_xor", {24'd0, rf[5]}, 32'h0C);

        // Destination equal to a source uses the old value.
        one(ADD, 3'd2, 3'd2, 3'd1, 8'h00, 8'h0E, 1'b0);
        chk("rf_r2_self", {24'd0, rf[2]}, 32'h0E);

        // Reset while LI R7,0x55 is in WRITE: the write is abandoned.
        one(LI, 3'd7, 3'd0, 3'd0, 8'h33, 8'h33, 1'b0);
        chk("rf_r7_pre", {24'd0, rf[7]}, 32'h33);
        issue(LI, 3'd7, 3'd0, 3'd0, 8'h55, 8'h55, 1'b0, 1'b0);
        ifc.instr_valid = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        chk("write_wen_before_rst", {31'd0, ifc.WEN}, 32'd1);
        chk("write_result_before_rst", {24'd0, ifc.result}, 32'h55);
        #1 Rst_n = 1'b0;
        #1;
        chk("midrst_wen", {31'd0, ifc.WEN}, 32'd0);
        chk("midrst_done", {31'd0, ifc.done}, 32'd0);
        chk("midrst_ready", {31'd0, ifc.instr_ready}, 32'd1);
        chk("midrst_result", {24'd0, ifc.result}, 32'd0);
        chk("midrst_carry", {31'd0, ifc.carry}, 32'd0);
        @(negedge Clk) Rst_n = 1'b1;
        @(posedge Clk); #1;
        chk("rf_r7_kept", {24'd0, rf[7]}, 32'h33);
        one(LI, 3'd7, 3'd0, 3'd0, 8'h66, 8'h66, 1'b0);
        chk("rf_r7_after_rst", {24'd0, rf[7]}, 32'h66);

        repeat (2) @(posedge Clk);
        #1;
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
